// File: rtl/cache_ram_ctrl_pkg.sv
// Shared types and helpers for the cache RAM controller: FSM state, write requester id,
// and a constant-friendly ceil(log2) used to size address fields.
package cache_ram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_e;

  // Returns at least 1 so a single-entry array still gets a one-bit address.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/cache_ram_ctrl_if.sv
// Bundle of cache-side requests and RAM-side pins around cache_ram_ctrl.
// master = cache logic plus RAM macro, slave = the controller itself.
interface cache_ram_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
);
  import cache_ram_pkg::*;

  localparam int unsigned AW   = clog2(DEPTH);
  localparam int unsigned BE_W = (WIDTH + 7) / 8;

  logic             flush_req;
  logic             busy;

  logic             wa_valid;
  logic             wa_ready;
  logic [AW-1:0]    wa_addr;
  logic [WIDTH-1:0] wa_data;
  logic [BE_W-1:0]  wa_be;

  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic [BE_W-1:0]  wb_be;

  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_gnt;
  logic             rd_data_valid;
  logic [WIDTH-1:0] rd_data;

  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_we;
  logic [BE_W-1:0]  ram_wbe;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  modport master (
    output flush_req,
    input  busy,
    output wa_valid, wa_addr, wa_data, wa_be,
    input  wa_ready,
    output wb_valid, wb_addr, wb_data, wb_be,
    input  wb_ready,
    output rd_req, rd_addr,
    input  rd_gnt, rd_data_valid, rd_data,
    input  ram_waddr, ram_wdata, ram_we, ram_wbe, ram_raddr,
    output ram_rdata
  );

  modport slave (
    input  flush_req,
    output busy,
    input  wa_valid, wa_addr, wa_data, wa_be,
    output wa_ready,
    input  wb_valid, wb_addr, wb_data, wb_be,
    output wb_ready,
    input  rd_req, rd_addr,
    output rd_gnt, rd_data_valid, rd_data,
    output ram_waddr, ram_wdata, ram_we, ram_wbe, ram_raddr,
    input  ram_rdata
  );

endinterface

// File: rtl/cache_ram_ctrl_bypass_merge.sv
// Byte-wise overlay of the previous cycle's write data onto the RAM read data when the
// registered write and read addresses matched.
module ram_bypass_merge #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BE_W  = (WIDTH + 7) / 8
) (
  input  logic             i_hit,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [BE_W-1:0]  i_wbe,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_data
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign o_data[g] = (i_hit && i_wbe[g / 8]) ? i_wdata[g] : i_rdata[g];
  end

endmodule

// File: rtl/cache_ram_ctrl.sv
// Cache dual-port RAM owner: clear sweep after reset/flush, round-robin write arbitration
// between refill (A) and store (B), one-cycle reads. Define CACHE_RAM_BYPASS_EN for
// same-cycle read-after-write forwarding.
module cache_ram_ctrl
  import cache_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  cache_ram_ctrl_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_clr_cnt;
  req_id_e       r_last_grant;
  logic          r_rd_valid;

  logic          w_run;
  logic          w_last_clear;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_rd_gnt;

  assign w_run        = (r_state == RUN);
  assign w_last_clear = (r_clr_cnt == AW'(DEPTH - 1));

  // The idle requester wins a tie; a lone requester always wins.
  assign w_grant_a = w_run && bus.wa_valid && (!bus.wb_valid || (r_last_grant == REQ_B));
  assign w_grant_b = w_run && bus.wb_valid && (!bus.wa_valid || (r_last_grant == REQ_A));
  assign w_rd_gnt  = w_run && bus.rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CLEAR: if (w_last_clear) w_state_next = RUN;
      RUN:   if (bus.flush_req) w_state_next = CLEAR;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b1;
    bus.wa_ready  = 1'b0;
    bus.wb_ready  = 1'b0;
    bus.rd_gnt    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_waddr = r_clr_cnt;
    bus.ram_wdata = '0;
    bus.ram_wbe   = '1;
    bus.ram_raddr = '0;
    unique case (r_state)
      CLEAR: begin
        bus.ram_we = 1'b1;
      end
      RUN: begin
        bus.busy      = 1'b0;
        bus.wa_ready  = w_grant_a;
        bus.wb_ready  = w_grant_b;
        bus.rd_gnt    = w_rd_gnt;
        bus.ram_raddr = bus.rd_addr;
        bus.ram_we    = w_grant_a || w_grant_b;
        if (w_grant_b) begin
          bus.ram_waddr = bus.wb_addr;
          bus.ram_wdata = bus.wb_data;
          bus.ram_wbe   = bus.wb_be;
        end else begin
          bus.ram_waddr = bus.wa_addr;
          bus.ram_wdata = bus.wa_data;
          bus.ram_wbe   = bus.wa_be;
        end
      end
    endcase
  end

  // Counter parks at 0 outside the sweep so a flush always restarts from the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt    <= '0;
      r_last_grant <= REQ_B;
      r_rd_valid   <= 1'b0;
    end else begin
      if (!w_run && !w_last_clear) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end else begin
        r_clr_cnt <= '0;
      end
      if (w_grant_a) begin
        r_last_grant <= REQ_A;
      end else if (w_grant_b) begin
        r_last_grant <= REQ_B;
      end
      r_rd_valid <= w_rd_gnt;
    end
  end

  assign bus.rd_data_valid = r_rd_valid;

`ifdef CACHE_RAM_BYPASS_EN
  localparam int unsigned BE_W = (WIDTH + 7) / 8;

  logic             r_byp_we;
  logic [AW-1:0]    r_byp_waddr;
  logic [AW-1:0]    r_byp_raddr;
  logic [WIDTH-1:0] r_byp_wdata;
  logic [BE_W-1:0]  r_byp_wbe;
  logic             w_byp_hit;
  logic [WIDTH-1:0] w_merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_we    <= 1'b0;
      r_byp_waddr <= '0;
      r_byp_raddr <= '0;
      r_byp_wdata <= '0;
      r_byp_wbe   <= '0;
    end else begin
      r_byp_we    <= w_run && bus.ram_we;
      r_byp_waddr <= bus.ram_waddr;
      r_byp_raddr <= bus.rd_addr;
      r_byp_wdata <= bus.ram_wdata;
      r_byp_wbe   <= bus.ram_wbe;
    end
  end

  assign w_byp_hit = r_byp_we && (r_byp_waddr == r_byp_raddr);

  ram_bypass_merge #(
    .WIDTH (WIDTH),
    .BE_W  (BE_W)
  ) u_bypass_merge (
    .i_hit   (w_byp_hit),
    .i_wdata (r_byp_wdata),
    .i_wbe   (r_byp_wbe),
    .i_rdata (bus.ram_rdata),
    .o_data  (w_merged)
  );

  assign bus.rd_data = r_rd_valid ? w_merged : '0;
`else
  assign bus.rd_data = r_rd_valid ? bus.ram_rdata : '0;
`endif

endmodule

// File: tb/tb_cache_ram_ctrl.sv
// Bench for cache_ram_ctrl: clear sweep, write arbitration table, read scoreboard,
// flush, and a DEPTH=12 instance with a reset pulse mid-sweep.
module tb_cache_ram_ctrl;

`ifdef CACHE_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  always #5 clk = ~clk;

  cache_ram_ctrl_if #(.WIDTH(32), .DEPTH(16)) if0 ();
  cache_ram_ctrl_if #(.WIDTH(32), .DEPTH(12)) if1 ();

  cache_ram_ctrl #(.WIDTH(32), .DEPTH(16)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
  cache_ram_ctrl #(.WIDTH(32), .DEPTH(12)) dut1 (.clk(clk), .rst(rst1), .bus(if1));

  // RAM models: registered address, combinational output; a same-address collision
  // returns the old word so the bypass path is actually exercised.
  logic [31:0] mem0 [16];
  logic [3:0]  raddr0_q;
  logic        coll0_q;
  logic [31:0] old0_q;
  always @(posedge clk) begin
    raddr0_q <= if0.ram_raddr;
    coll0_q  <= if0.ram_we && (if0.ram_waddr == if0.ram_raddr);
    old0_q   <= mem0[if0.ram_raddr];
    if (if0.ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (if0.ram_wbe[b]) mem0[if0.ram_waddr][b*8 +: 8] <= if0.ram_wdata[b*8 +: 8];
      end
    end
  end
  assign if0.ram_rdata = coll0_q ? old0_q : mem0[raddr0_q];

  logic [31:0] mem1 [16];
  logic [3:0]  raddr1_q;
  always @(posedge clk) begin
    raddr1_q <= if1.ram_raddr;
    if (if1.ram_we) mem1[if1.ram_waddr] <= if1.ram_wdata;
  end
  assign if1.ram_rdata = mem1[raddr1_q];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Reference contents and read scoreboard.
  logic [31:0] ref_mem [16];
  typedef struct {
    logic [31:0] data;
    bit          skip;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  task automatic push_rd(input logic [3:0] addr, input bit skip);
    sb_t e;
    e.data = ref_mem[addr];
    e.skip = skip;
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  sb_t e_mon;
  always @(negedge clk) begin
    if (!rst0 && if0.rd_data_valid) begin
      if (sb_q.size() == 0) begin
        chk("rd_valid_unexpected", 32'(if0.rd_data_valid), 32'd0);
      end else begin
        e_mon = sb_q.pop_front();
        chk("rd_latency", cyc, e_mon.cyc + 1);
        if (!e_mon.skip) chk("rd_data", if0.rd_data, e_mon.data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && if1.ram_we) chk("d12_waddr_in_range", 32'(if1.ram_waddr < 4'd12), 32'd1);
  end

  typedef struct {
    bit          wa_v;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic [3:0]  wa_be;
    bit          wb_v;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    bit          rd;
    logic [3:0]  rd_addr;
    bit          exp_a;
    bit          exp_b;
  } vec_t;
  vec_t tbl [15];

  task automatic zero_inputs();
    if0.flush_req = 0; if0.wa_valid = 0; if0.wb_valid = 0; if0.rd_req = 0;
    if0.wa_addr = 0; if0.wa_data = 0; if0.wa_be = 0;
    if0.wb_addr = 0; if0.wb_data = 0; if0.wb_be = 0; if0.rd_addr = 0;
  endtask

  initial begin
    // Starting last_grant is B; ties alternate, lone requesters always win.
    tbl[0]  = '{1, 4'd3,  32'h11111111, 4'hF, 1, 4'd5,  32'h55555555, 4'hF, 0, 4'd0,  1, 0};
    tbl[1]  = '{1, 4'd3,  32'h33333333, 4'hF, 1, 4'd5,  32'h55555555, 4'hF, 0, 4'd0,  0, 1};
    tbl[2]  = '{1, 4'd3,  32'h33333333, 4'hF, 1, 4'd5,  32'h5555AAAA, 4'hF, 0, 4'd0,  1, 0};
    tbl[3]  = '{1, 4'd3,  32'h44444444, 4'hF, 1, 4'd5,  32'h5555AAAA, 4'hF, 0, 4'd0,  0, 1};
    tbl[4]  = '{1, 4'd7,  32'hDEADBEEF, 4'hF, 1, 4'd9,  32'h99999999, 4'hF, 1, 4'd3,  1, 0};
    tbl[5]  = '{0, 4'd0,  32'h0,        4'h0, 1, 4'd9,  32'h99999999, 4'hF, 1, 4'd7,  0, 1};
    tbl[6]  = '{0, 4'd0,  32'h0,        4'h0, 1, 4'd1,  32'h0000BEEF, 4'h3, 1, 4'd5,  0, 1};
    tbl[7]  = '{1, 4'd2,  32'h11223344, 4'hF, 0, 4'd0,  32'h0,        4'h0, 1, 4'd9,  1, 0};
    tbl[8]  = '{0, 4'd0,  32'h0,        4'h0, 0, 4'd0,  32'h0,        4'h0, 1, 4'd1,  0, 0};
    tbl[9]  = '{1, 4'd10, 32'hCAFEF00D, 4'hC, 1, 4'd11, 32'h12345678, 4'h1, 1, 4'd2,  0, 1};
    tbl[10] = '{1, 4'd10, 32'hCAFEF00D, 4'hC, 0, 4'd0,  32'h0,        4'h0, 1, 4'd11, 1, 0};
    tbl[11] = '{0, 4'd0,  32'h0,        4'h0, 0, 4'd0,  32'h0,        4'h0, 1, 4'd10, 0, 0};
    tbl[12] = '{1, 4'd12, 32'h0C0C0C0C, 4'hF, 1, 4'd13, 32'h0D0D0D0D, 4'hF, 1, 4'd12, 0, 1};
    tbl[13] = '{1, 4'd12, 32'h0C0C0C0C, 4'hF, 0, 4'd0,  32'h0,        4'h0, 0, 4'd0,  1, 0};
    tbl[14] = '{0, 4'd0,  32'h0,        4'h0, 0, 4'd0,  32'h0,        4'h0, 1, 4'd12, 0, 0};

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst0 = 1; rst1 = 1;
    zero_inputs();
    if1.flush_req = 0; if1.wa_valid = 0; if1.wb_valid = 0; if1.rd_req = 0;
    if1.wa_addr = 0; if1.wa_data = 0; if1.wa_be = 0;
    if1.wb_addr = 0; if1.wb_data = 0; if1.wb_be = 0; if1.rd_addr = 0;
    if0.wa_valid = 1; if0.wb_valid = 1; if0.rd_req = 1;

    // Reset values.
    @(negedge clk);
    chk("rst_busy", 32'(if0.busy), 32'd1);
    chk("rst_ram_we", 32'(if0.ram_we), 32'd1);
    chk("rst_ram_waddr", 32'(if0.ram_waddr), 32'd0);
    chk("rst_wa_ready", 32'(if0.wa_ready), 32'd0);
    chk("rst_wb_ready", 32'(if0.wb_ready), 32'd0);
    chk("rst_rd_gnt", 32'(if0.rd_gnt), 32'd0);
    chk("rst_rd_valid", 32'(if0.rd_data_valid), 32'd0);
    chk("rst_rd_data", if0.rd_data, 32'd0);
    tick();
    rst0 = 0;

    // Sweep after reset, with requests and a stray flush held against it.
    for (int k = 0; k <= 16; k++) begin
      if0.flush_req = (k >= 3 && k <= 6);
      if (k == 16) zero_inputs();
      @(negedge clk);
      if (k < 16) begin
        chk($sformatf("clr%0d_busy", k), 32'(if0.busy), 32'd1);
        chk($sformatf("clr%0d_we", k), 32'(if0.ram_we), 32'd1);
        chk($sformatf("clr%0d_waddr", k), 32'(if0.ram_waddr), 32'(k));
        chk($sformatf("clr%0d_wdata", k), if0.ram_wdata, 32'd0);
        chk($sformatf("clr%0d_wbe", k), 32'(if0.ram_wbe), 32'hF);
        chk($sformatf("clr%0d_rdy", k), 32'({if0.wa_ready, if0.wb_ready, if0.rd_gnt}), 32'd0);
      end else begin
        chk("clr_done_busy", 32'(if0.busy), 32'd0);
        chk("clr_done_we", 32'(if0.ram_we), 32'd0);
      end
      tick();
    end

    // Arbitration and read table.
    for (int i = 0; i < 15; i++) begin
      vec_t v;
      bit   coll;
      v = tbl[i];
      if0.wa_valid = v.wa_v; if0.wa_addr = v.wa_addr; if0.wa_data = v.wa_data;
      if0.wa_be = v.wa_be;
      if0.wb_valid = v.wb_v; if0.wb_addr = v.wb_addr; if0.wb_data = v.wb_data;
      if0.wb_be = v.wb_be;
      if0.rd_req = v.rd; if0.rd_addr = v.rd_addr;
      coll = (v.exp_a && v.wa_addr == v.rd_addr) || (v.exp_b && v.wb_addr == v.rd_addr);
      if (v.exp_a) ref_mem[v.wa_addr] = bmerge(ref_mem[v.wa_addr], v.wa_data, v.wa_be);
      if (v.exp_b) ref_mem[v.wb_addr] = bmerge(ref_mem[v.wb_addr], v.wb_data, v.wb_be);
      if (v.rd) push_rd(v.rd_addr, coll && !BYPASS);
      @(negedge clk);
      chk($sformatf("v%0d_wa_ready", i), 32'(if0.wa_ready), 32'(v.exp_a));
      chk($sformatf("v%0d_wb_ready", i), 32'(if0.wb_ready), 32'(v.exp_b));
      chk($sformatf("v%0d_ram_we", i), 32'(if0.ram_we), 32'(v.exp_a | v.exp_b));
      chk($sformatf("v%0d_rd_gnt", i), 32'(if0.rd_gnt), 32'(v.rd));
      if (v.exp_a | v.exp_b) begin
        chk($sformatf("v%0d_waddr", i), 32'(if0.ram_waddr), 32'(v.exp_a ? v.wa_addr : v.wb_addr));
        chk($sformatf("v%0d_wdata", i), if0.ram_wdata, v.exp_a ? v.wa_data : v.wb_data);
        chk($sformatf("v%0d_wbe", i), 32'(if0.ram_wbe), 32'(v.exp_a ? v.wa_be : v.wb_be));
      end
      tick();
    end
    zero_inputs();

    // Same-cycle write and read of addr 2 (holds 11223344), then a plain re-read.
    if0.wa_valid = 1; if0.wa_addr = 4'd2; if0.wa_data = 32'hAABBCCDD; if0.wa_be = 4'b0011;
    if0.rd_req = 1; if0.rd_addr = 4'd2;
    ref_mem[2] = bmerge(ref_mem[2], 32'hAABBCCDD, 4'b0011);
    push_rd(4'd2, !BYPASS);
    @(negedge clk);
    chk("raw_wa_ready", 32'(if0.wa_ready), 32'd1);
    tick();
    if0.wa_valid = 0;
    push_rd(4'd2, 1'b0);
    tick();
    zero_inputs();
    tick();

    // Flush while B transfers; B lands, then the whole array is cleared.
    if0.flush_req = 1; if0.wb_valid = 1; if0.wb_addr = 4'd6; if0.wb_data = 32'h66666666;
    if0.wb_be = 4'hF;
    @(negedge clk);
    chk("fl_wb_ready", 32'(if0.wb_ready), 32'd1);
    chk("fl_ram_we", 32'(if0.ram_we), 32'd1);
    chk("fl_waddr", 32'(if0.ram_waddr), 32'd6);
    chk("fl_busy", 32'(if0.busy), 32'd0);
    tick();
    zero_inputs();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    if0.rd_req = 1; if0.rd_addr = 4'd6;
    for (int k = 0; k <= 16; k++) begin
      if (k == 16) if0.rd_req = 0;
      @(negedge clk);
      if (k < 16) begin
        chk($sformatf("fl%0d_busy", k), 32'(if0.busy), 32'd1);
        chk($sformatf("fl%0d_waddr", k), 32'(if0.ram_waddr), 32'(k));
        chk($sformatf("fl%0d_rd_gnt", k), 32'(if0.rd_gnt), 32'd0);
      end else begin
        chk("fl_done_busy", 32'(if0.busy), 32'd0);
      end
      tick();
    end
    if0.rd_req = 1; if0.rd_addr = 4'd6; push_rd(4'd6, 1'b0);
    tick();
    if0.rd_addr = 4'd3; push_rd(4'd3, 1'b0);
    tick();
    zero_inputs();
    tick();
    tick();

    // DEPTH=12 instance: reset pulse at sweep cycle 5, then a full sweep.
    rst1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("d12a%0d_waddr", k), 32'(if1.ram_waddr), 32'(k));
      tick();
    end
    rst1 = 1;
    @(negedge clk);
    chk("d12_rst_waddr", 32'(if1.ram_waddr), 32'd0);
    chk("d12_rst_busy", 32'(if1.busy), 32'd1);
    tick();
    rst1 = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k < 12) begin
        chk($sformatf("d12b%0d_waddr", k), 32'(if1.ram_waddr), 32'(k));
        chk($sformatf("d12b%0d_busy", k), 32'(if1.busy), 32'd1);
      end else begin
        chk("d12_done_busy", 32'(if1.busy), 32'd0);
        chk("d12_done_we", 32'(if1.ram_we), 32'd0);
      end
      tick();
    end

    // A read whose data-valid is pending when reset hits must be dropped.
    if1.rd_req = 1;
    @(negedge clk);
    chk("d12_rd_gnt", 32'(if1.rd_gnt), 32'd1);
    tick();
    if1.rd_req = 0;
    rst1 = 1;
    @(negedge clk);
    chk("d12_drop_rd_valid", 32'(if1.rd_data_valid), 32'd0);
    chk("d12_drop_rd_data", if1.rd_data, 32'd0);
    chk("d12_drop_busy", 32'(if1.busy), 32'd1);
    tick();
    rst1 = 0;
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
